// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data_memory: one write per cycle or one read per two cycles.
// Define MEM_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed priority to port 0.
module mem_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [WORD_SIZE-1:0] addr0,
  input  logic [WORD_SIZE-1:0] addr1,
  input  logic [WORD_SIZE-1:0] wdata0,
  input  logic [WORD_SIZE-1:0] wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [WORD_SIZE-1:0] rdata0,
  output logic [WORD_SIZE-1:0] rdata1,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_val,
  output logic                 mem_get,
  output logic                 mem_set,
  input  logic [WORD_SIZE-1:0] mem_out
);

  typedef enum logic {IDLE, READ_WAIT} state_t;

  state_t               state, state_nxt;
  logic                 owner, owner_nxt;   // port that owns the outstanding read
  logic [WORD_SIZE-1:0] rdata0_q, rdata1_q;
  logic                 sel;                // winning port when a grant is issued
  logic                 grant;
  logic                 sel_we;

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic ptr;  // port that wins the next contention

  always_ff @(posedge clk) begin
    if (reset)      ptr <= 1'b0;
    else if (grant) ptr <= ~sel;
  end

  assign sel = (req0 && req1) ? ptr : req1;
`else
  assign sel = ~req0;
`endif

  assign grant  = (state == IDLE) && (req0 || req1) && !reset;
  assign sel_we = sel ? we1 : we0;

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;
    mem_addr  = '0;
    mem_val   = '0;
    mem_get   = 1'b0;
    mem_set   = 1'b0;
    case (state)
      IDLE: begin
        if (grant) begin
          gnt0     = ~sel;
          gnt1     = sel;
          mem_addr = sel ? addr1 : addr0;
          mem_val  = sel ? wdata1 : wdata0;
          mem_set  = sel_we;
          mem_get  = ~sel_we;
          if (!sel_we) begin
            state_nxt = READ_WAIT;
            owner_nxt = sel;
          end
        end
      end
      READ_WAIT: begin
        // A reset landing here drops the read without a response.
        if (!reset) begin
          rvalid0   = ~owner;
          rvalid1   = owner;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rdata0 = rvalid0 ? mem_out : rdata0_q;
  assign rdata1 = rvalid1 ? mem_out : rdata1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      if (rvalid0) rdata0_q <= mem_out;
      if (rvalid1) rdata1_q <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural data_memory, expected read data queued per port
// when a read is driven and popped on rvalid.
module tb_mem_arbiter;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0, req1, we0, we1;
  logic [W-1:0] addr0, addr1, wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [W-1:0] rdata0, rdata1, mem_addr, mem_val, mem_out;
  logic         mem_get, mem_set;

  logic [W-1:0] mem [0:255];
  logic [W-1:0] ref_mem [0:255];
  logic [W-1:0] exp0_q[$], exp1_q[$];
  int total = 0;
  int bad   = 0;

  mem_arbiter #(.WORD_SIZE(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_val(mem_val), .mem_get(mem_get), .mem_set(mem_set),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // data_memory stand-in: synchronous write, registered read
  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    mem_out = '0;
  end
  always @(posedge clk) begin
    if (mem_set) mem[mem_addr[7:0]] <= mem_val;
    if (mem_get) mem_out <= mem[mem_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // exclusivity and rvalid scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    chk("gnt_excl", {31'b0, gnt0 & gnt1}, 0);
    chk("rvalid_excl", {31'b0, rvalid0 & rvalid1}, 0);
    if (rvalid0) begin
      if (exp0_q.size() == 0) chk("sb0_unexpected", 1, 0);
      else chk("rdata0", {16'b0, rdata0}, {16'b0, exp0_q.pop_front()});
    end
    if (rvalid1) begin
      if (exp1_q.size() == 0) chk("sb1_unexpected", 1, 0);
      else chk("rdata1", {16'b0, rdata1}, {16'b0, exp1_q.pop_front()});
    end
  end

  initial begin
    idle_inputs();
    // reset state, with a pending request that must not be granted
    reset = 1'b1;
    req0 = 1; we0 = 1; addr0 = 16'd5; wdata0 = 16'h55;
    tick();
    tick();
    @(negedge clk);
    chk("rst_gnt0", {31'b0, gnt0}, 0);
    chk("rst_set", {31'b0, mem_set}, 0);
    chk("rst_get", {31'b0, mem_get}, 0);
    chk("rst_rv", {30'b0, rvalid0, rvalid1}, 0);
    chk("rst_rdata", {rdata0, rdata1}, 0);
    chk("rst_addr", {16'b0, mem_addr}, 0);
    tick();
    reset = 1'b0;
    idle_inputs();

    // three back-to-back writes from port 0
    for (int i = 1; i <= 3; i++) begin
      req0 = 1; we0 = 1; addr0 = W'(i); wdata0 = W'(i * i);
      ref_mem[i] = W'(i * i);
      @(negedge clk);
      chk("wr_gnt0", {31'b0, gnt0}, 1);
      chk("wr_set", {30'b0, mem_set, mem_get}, 2'b10);
      chk("wr_addr", {16'b0, mem_addr}, i);
      chk("wr_val", {16'b0, mem_val}, i * i);
      tick();
    end
    // read addr 2 back
    we0 = 0; addr0 = 16'd2;
    exp0_q.push_back(ref_mem[2]);
    @(negedge clk);
    chk("rd_gnt0", {31'b0, gnt0}, 1);
    chk("rd_get", {30'b0, mem_set, mem_get}, 2'b01);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("rd_rvalid0", {31'b0, rvalid0}, 1);
    chk("rd_wait_nognt", {30'b0, gnt0, gnt1}, 0);
    tick();
    @(negedge clk);
    chk("rd_rvalid0_off", {31'b0, rvalid0}, 0);
    chk("rd_hold", {16'b0, rdata0}, 16'h0004);
    tick();

    // simultaneous reads: port 0 first, port 1 two cycles later
    do_reset();
    req0 = 1; we0 = 0; addr0 = 16'd1;
    req1 = 1; we1 = 0; addr1 = 16'd3;
    exp0_q.push_back(ref_mem[1]);
    exp1_q.push_back(ref_mem[3]);
    @(negedge clk);
    chk("dual_gnt_c0", {30'b0, gnt0, gnt1}, 2'b10);
    chk("dual_addr_c0", {16'b0, mem_addr}, 1);
    tick();
    req0 = 0;
    @(negedge clk);
    chk("dual_gnt_c1", {30'b0, gnt0, gnt1}, 0);
    chk("dual_rv_c1", {30'b0, rvalid0, rvalid1}, 2'b10);
    tick();
    @(negedge clk);
    chk("dual_gnt_c2", {30'b0, gnt0, gnt1}, 2'b01);
    chk("dual_addr_c2", {16'b0, mem_addr}, 3);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("dual_rv_c3", {30'b0, rvalid0, rvalid1}, 2'b01);
    tick();
    @(negedge clk);
    chk("dual_hold", {rdata0, rdata1}, {16'h0001, 16'h0009});
    tick();

    // continuous write contention for six cycles
    do_reset();
    req0 = 1; we0 = 1; addr0 = 16'd10; wdata0 = 16'hA0;
    req1 = 1; we1 = 1; addr1 = 16'd11; wdata1 = 16'hB1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      chk("cont_gnt", {30'b0, gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
`else
      chk("cont_gnt", {30'b0, gnt0, gnt1}, 2'b10);
`endif
      chk("cont_set", {31'b0, mem_set}, 1);
      tick();
    end
    idle_inputs();
    ref_mem[10] = 16'hA0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    ref_mem[11] = 16'hB1;
`endif

    // reset during port 1 READ_WAIT aborts the read
    do_reset();
    req1 = 1; we1 = 0; addr1 = 16'd3;
    @(negedge clk);
    chk("ab_gnt1", {30'b0, gnt0, gnt1}, 2'b01);
    tick();
    req1 = 0;
    reset = 1;
    req0 = 1; we0 = 0; addr0 = 16'd2;
    @(negedge clk);
    chk("ab_rv", {30'b0, rvalid0, rvalid1}, 0);
    chk("ab_gnt_rst", {30'b0, gnt0, gnt1}, 0);
    chk("ab_rdata1", {16'b0, rdata1}, 0);
    tick();
    reset = 0;
    exp0_q.push_back(ref_mem[2]);
    @(negedge clk);
    chk("ab_first_gnt0", {31'b0, gnt0}, 1);
    chk("ab_rdata1_post", {16'b0, rdata1}, 0);
    tick();
    idle_inputs();
    tick();

    // port 1 pulses req during port 0 READ_WAIT, then withdraws
    req0 = 1; we0 = 0; addr0 = 16'd3;
    exp0_q.push_back(ref_mem[3]);
    @(negedge clk);
    chk("wd_gnt0", {31'b0, gnt0}, 1);
    tick();
    req0 = 0;
    req1 = 1; we1 = 0; addr1 = 16'd1;
    @(negedge clk);
    chk("wd_gnt1_wait", {31'b0, gnt1}, 0);
    chk("wd_get_wait", {31'b0, mem_get}, 0);
    tick();
    req1 = 0;
    @(negedge clk);
    chk("wd_gnt1_after", {31'b0, gnt1}, 0);
    chk("wd_idle_bus", {mem_addr, mem_val}, 0);
    chk("wd_idle_ctl", {30'b0, mem_get, mem_set}, 0);
    tick();
    tick();

    chk("sb0_drained", exp0_q.size(), 0);
    chk("sb1_drained", exp1_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: WORD_SIZE, 16, data and address width (matches data_memory).
REQ-002 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: req0, req1  input  1 each  access request from port 0 (CPU) and port 1 (debug/loader).
REQ-005 SHALL have ports: we0, we1  input  1 each  1 = write (set), 0 = read (get).
REQ-006 SHALL have ports: addr0, addr1, wdata0, wdata1  input  WORD_SIZE each  address and write value per port.
REQ-007 SHALL have ports: gnt0, gnt1  output  1 each  access accepted this cycle.
REQ-008 SHALL have ports: rvalid0, rvalid1  output  1 each  read data valid this cycle.
REQ-009 SHALL have ports: rdata0, rdata1  output  WORD_SIZE each  read result per port.
REQ-010 SHALL have ports: mem_addr, mem_val  output  WORD_SIZE each, plus mem_get, mem_set  output  1 each, and mem_out  input  WORD_SIZE; these connect to data_memory.

Function
REQ-011 SHALL implement two states: IDLE and READ_WAIT.
REQ-012 In IDLE, when any req is high, SHALL grant exactly one port combinationally in the same cycle: gnt high, and mem_addr/mem_val/mem_set/mem_get driven from that port's inputs.
REQ-013 A granted write SHALL assert mem_set for exactly that cycle, and the state SHALL stay IDLE (one access per cycle).
REQ-014 A granted read SHALL assert mem_get for exactly that cycle, and the state SHALL move to READ_WAIT.
REQ-015 In READ_WAIT, SHALL assert rvalid of the read's owner for one cycle with rdata = mem_out, capture mem_out into that port's rdata register, and return to IDLE; no grants SHALL be issued in READ_WAIT.
REQ-016 Outside its rvalid cycle, each rdataN SHALL hold its last captured value.
REQ-017 A requester SHALL hold req, we, addr and wdata stable until gnt. The arbiter SHALL treat a req dropped before gnt as withdrawn, with no access made.
REQ-018 When no port is granted, mem_get and mem_set SHALL be 0, and mem_addr and mem_val SHALL be 0.
REQ-019 gnt0 and gnt1 SHALL never both be high; rvalid0 and rvalid1 SHALL never both be high.
REQ-020 With simultaneous requests, the winner SHALL follow the arbitration policy in REQ-026/027; the loser's req stays pending.
REQ-021 Throughput: one write per cycle, or one read per two cycles.

Reset
REQ-022 While reset is high, the state SHALL be IDLE, gnt*/rvalid*/mem_get/mem_set SHALL be 0, and rdata0/rdata1 SHALL be 0.
REQ-023 Reset in READ_WAIT SHALL abort the read: no rvalid is issued and rdata is unchanged from its reset value of 0.
REQ-024 The round-robin pointer SHALL reset so that port 0 wins the first contention.
REQ-025 The first grant SHALL be possible in the first cycle after reset deasserts.

Configuration
REQ-026 With macro MEM_ARBITER_ROUND_ROBIN_EN defined, SHALL use round-robin: after a grant to port k, the other port wins the next contention.
REQ-027 Without MEM_ARBITER_ROUND_ROBIN_EN, SHALL use fixed priority: port 0 always wins contention, and the round-robin pointer logic SHALL be absent.

Verification
REQ-028 Port 0 writes addr 1 = 0x0001, addr 2 = 0x0004, addr 3 = 0x0009 on consecutive cycles -> gnt0 high each cycle and mem_set pulses 3 times; port 0 then reads addr 2 -> mem_get at N, rvalid0 at N+1 with rdata0 = 0x0004, then held.
REQ-029 Both ports request reads in the same cycle (addr 1, addr 3) -> port 0 is served first, port 1 granted 2 cycles later, rdata0 = 0x0001 and rdata1 = 0x0009, and gnt/rvalid are never simultaneous.
REQ-030 Both ports hold continuous write requests for 6 cycles -> with MEM_ARBITER_ROUND_ROBIN_EN grants alternate 0,1,0,1,0,1; without it gnt0 is high all 6 cycles and gnt1 never.
REQ-031 Reset asserted in the READ_WAIT cycle of a port 1 read -> no rvalid1, rdata1 = 0, state IDLE, and a port 0 request is granted on the first cycle after reset release.
REQ-032 Port 1 raises req with we = 0 for one cycle while port 0 holds a read in progress (READ_WAIT), then drops it -> no gnt1 and no mem_get for port 1.
